// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register: issues loads/stores over a req/ack
// handshake to a variable-latency data memory and stalls upstream until each completes.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic        Memorywrite_i,
    input  logic        Memoryread_i,
    input  logic [31:0] ALU_o_i,
    input  logic [31:0] fw2_i,
    input  logic [4:0]  Rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        err_o,
    output logic [1:0]  WB_o,
    output logic [31:0] MemData_o,
    output logic [31:0] ALU_o_o,
    output logic [4:0]  Rd_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [1:0]  wb_q, wb_d;
    logic [31:0] memdata_q, memdata_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  rd_q, rd_d;

    logic acc;
    assign acc = Memoryread_i | Memorywrite_i;

    // Gated by reset so upstream unfreezes the instant reset hits, even mid-access.
    assign stall_o = !rst_i && ((state_q == BUSY) || ((state_q == IDLE) && acc));

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        wb_d      = wb_q;
        memdata_d = memdata_q;
        alu_d     = alu_q;
        rd_d      = rd_q;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    req_d   = 1'b1;
                    we_d    = Memorywrite_i;
                    addr_d  = ALU_o_i;
                    wdata_d = fw2_i;
                    cnt_d   = '0;
                    wb_d    = '0;
                    rd_d    = '0;
                    state_d = BUSY;
                end else begin
                    wb_d  = WB_i;
                    alu_d = ALU_o_i;
                    rd_d  = Rd_i;
                end
            end

            BUSY: begin
                wb_d = '0;
                rd_d = '0;
                if (mem_ack_i) begin
                    req_d = 1'b0;
                    if (!we_q) memdata_d = mem_rdata_i;
                    state_d = DONE;
                end else if (cnt_q == LAST_CNT) begin
                    req_d = 1'b0;
                    if (!we_q) memdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                // EX/MEM still holds the instruction that just completed; do not re-issue it.
                wb_d    = WB_i;
                alu_d   = ALU_o_i;
                rd_d    = Rd_i;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            wb_q      <= '0;
            memdata_q <= '0;
            alu_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            wb_q      <= wb_d;
            memdata_q <= memdata_d;
            alu_q     <= alu_d;
            rd_q      <= rd_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign err_o       = err_q;
    assign WB_o        = wb_q;
    assign MemData_o   = memdata_q;
    assign ALU_o_o     = alu_q;
    assign Rd_o        = rd_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: plain op, load, store, timeout, back-to-back loads,
// and reset in the middle of an access, with the memory side driven by hand.
module tb_mem_wb_stage;

    logic        clk_i;
    logic        rst_i;
    logic [1:0]  WB_i;
    logic        Memorywrite_i;
    logic        Memoryread_i;
    logic [31:0] ALU_o_i;
    logic [31:0] fw2_i;
    logic [4:0]  Rd_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        err_o;
    logic [1:0]  WB_o;
    logic [31:0] MemData_o;
    logic [31:0] ALU_o_o;
    logic [4:0]  Rd_o;

    int checks   = 0;
    int failures = 0;

    mem_wb_stage #(
        .TIMEOUT_CYC (4),
        .ERR_DATA    (32'hDEADBEEF)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .WB_i          (WB_i),
        .Memorywrite_i (Memorywrite_i),
        .Memoryread_i  (Memoryread_i),
        .ALU_o_i       (ALU_o_i),
        .fw2_i         (fw2_i),
        .Rd_i          (Rd_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .stall_o       (stall_o),
        .err_o         (err_o),
        .WB_o          (WB_o),
        .MemData_o     (MemData_o),
        .ALU_o_o       (ALU_o_o),
        .Rd_o          (Rd_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it, away from the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ex(input logic [1:0] wb, input logic rd_s, input logic wr_s,
                          input logic [31:0] alu, input logic [31:0] fw2, input logic [4:0] rd);
        WB_i          = wb;
        Memoryread_i  = rd_s;
        Memorywrite_i = wr_s;
        ALU_o_i       = alu;
        fw2_i         = fw2;
        Rd_i          = rd;
    endtask

    initial begin
        rst_i       = 1'b1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        set_ex(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        check("rst_req",   mem_req_o, 0);
        check("rst_we",    mem_we_o, 0);
        check("rst_addr",  mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_err",   err_o, 0);
        check("rst_wb",    WB_o, 0);
        check("rst_mdata", MemData_o, 0);
        check("rst_alu",   ALU_o_o, 0);
        check("rst_rd",    Rd_o, 0);
        check("rst_stall", stall_o, 0);
        rst_i = 1'b0;

        // Non-memory op: one-cycle pass-through, no stall.
        set_ex(2'b10, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
        #1 check("nop_stall", stall_o, 0);
        tick();
        check("nop_wb",    WB_o, 2'b10);
        check("nop_alu",   ALU_o_o, 32'h1234);
        check("nop_rd",    Rd_o, 5);
        check("nop_mdata", MemData_o, 0);

        // Load, ack in third request cycle: 4 stall cycles.
        set_ex(2'b11, 1'b1, 1'b0, 32'h40, 32'h99, 5'd7);
        #1 check("ld_stall0", stall_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hCAFEF00D;
            end
            #1;
            check("ld_req",   mem_req_o, 1);
            check("ld_addr",  mem_addr_o, 32'h40);
            check("ld_we",    mem_we_o, 0);
            check("ld_stall", stall_o, 1);
            check("ld_wb",    WB_o, 0);
            check("ld_rd",    Rd_o, 0);
            check("ld_alu_hold", ALU_o_o, 32'h1234);
        end
        tick();
        // Ack outside BUSY must be ignored.
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h11111111;
        #1;
        check("ld_done_req",   mem_req_o, 0);
        check("ld_done_stall", stall_o, 0);
        check("ld_done_wb",    WB_o, 0);
        check("ld_done_mdata", MemData_o, 32'hCAFEF00D);
        tick();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        check("ld_out_wb",    WB_o, 2'b11);
        check("ld_out_rd",    Rd_o, 7);
        check("ld_out_alu",   ALU_o_o, 32'h40);
        check("ld_out_mdata", MemData_o, 32'hCAFEF00D);
        check("ld_no_reissue", mem_req_o, 0);

        // Store, ack in the first request cycle: 2 stall cycles, MemData unchanged.
        set_ex(2'b01, 1'b0, 1'b1, 32'h80, 32'h55, 5'd3);
        #1 check("st_stall0", stall_o, 1);
        tick();
        mem_ack_i = 1'b1;
        #1;
        check("st_req",   mem_req_o, 1);
        check("st_we",    mem_we_o, 1);
        check("st_wdata", mem_wdata_o, 32'h55);
        check("st_addr",  mem_addr_o, 32'h80);
        check("st_stall1", stall_o, 1);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("st_done_stall", stall_o, 0);
        check("st_done_req",   mem_req_o, 0);
        check("st_done_mdata", MemData_o, 32'hCAFEF00D);
        tick();
        check("st_out_wb",    WB_o, 2'b01);
        check("st_out_rd",    Rd_o, 3);
        check("st_out_alu",   ALU_o_o, 32'h80);
        check("st_out_mdata", MemData_o, 32'hCAFEF00D);

        // Load with no ack: times out after 4 request cycles.
        set_ex(2'b11, 1'b1, 1'b0, 32'hC0, 32'h0, 5'd9);
        #1;
        check("to_stall0", stall_o, 1);
        check("to_err0",   err_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_req",   mem_req_o, 1);
            check("to_stall", stall_o, 1);
            check("to_err_lo", err_o, 0);
        end
        tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h22222222;
        #1;
        check("to_done_req",   mem_req_o, 0);
        check("to_done_err",   err_o, 1);
        check("to_done_mdata", MemData_o, 32'hDEADBEEF);
        check("to_done_stall", stall_o, 0);
        tick();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        check("to_out_wb",    WB_o, 2'b11);
        check("to_out_rd",    Rd_o, 9);
        check("to_out_mdata", MemData_o, 32'hDEADBEEF);

        // Two consecutive loads: separate requests, separate MEM/WB slots.
        set_ex(2'b11, 1'b1, 1'b0, 32'h100, 32'h0, 5'd10);
        tick();
        check("b2b_a_req",  mem_req_o, 1);
        check("b2b_a_addr", mem_addr_o, 32'h100);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hAAAA0001;
        tick();
        mem_ack_i   = 1'b0;
        check("b2b_a_done_req",   mem_req_o, 0);
        check("b2b_a_done_mdata", MemData_o, 32'hAAAA0001);
        tick();
        check("b2b_a_rd",    Rd_o, 10);
        check("b2b_a_mdata", MemData_o, 32'hAAAA0001);
        check("b2b_no_dup",  mem_req_o, 0);
        set_ex(2'b11, 1'b1, 1'b0, 32'h104, 32'h0, 5'd11);
        #1 check("b2b_b_stall0", stall_o, 1);
        tick();
        check("b2b_b_req",  mem_req_o, 1);
        check("b2b_b_addr", mem_addr_o, 32'h104);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBBBB0002;
        tick();
        mem_ack_i   = 1'b0;
        check("b2b_b_done_mdata", MemData_o, 32'hBBBB0002);
        tick();
        check("b2b_b_rd",    Rd_o, 11);
        check("b2b_b_wb",    WB_o, 2'b11);
        check("b2b_b_mdata", MemData_o, 32'hBBBB0002);
        check("err_sticky",  err_o, 1);

        // Reset in the middle of BUSY, then a stray ack after release.
        set_ex(2'b11, 1'b1, 1'b0, 32'h200, 32'h0, 5'd12);
        tick();
        check("rb_req_pre", mem_req_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("rb_req",   mem_req_o, 0);
        check("rb_stall", stall_o, 0);
        check("rb_err",   err_o, 0);
        check("rb_mdata", MemData_o, 0);
        tick();
        rst_i = 1'b0;
        set_ex(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h33333333;
        tick();
        mem_ack_i = 1'b0;
        check("rb_late_ack_mdata", MemData_o, 0);
        check("rb_late_ack_req",   mem_req_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
